// File: rtl/btb_update_if.sv
// btb_update_if: resolved-branch input handshake and BTB write-port bundle
interface btb_update_if;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_pc;
  logic [15:0] res_target;
  logic        res_taken;
  logic        btb_write_ok;
  logic [15:0] loaded_pc;
  logic [15:0] loaded_predict_pc;
  logic        new_predict_val;
  logic        load_line;
  logic [15:0] mispredict_cnt;
  modport master (
    output res_valid, res_pc, res_target, res_taken, btb_write_ok,
    input  res_ready, loaded_pc, loaded_predict_pc, new_predict_val, load_line, mispredict_cnt
  );
  modport slave (
    input  res_valid, res_pc, res_target, res_taken, btb_write_ok,
    output res_ready, loaded_pc, loaded_predict_pc, new_predict_val, load_line, mispredict_cnt
  );
endinterface

// File: rtl/btb_update_unit.sv
// btb_update_unit: buffers resolved branches and drives the two-cycle BTB write sequence
module btb_update_unit #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 3
) (
  input logic         clk,
  input logic         reset,
  btb_update_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int N = 1 << IDX_W;
  typedef enum logic [1:0] {IDLE, SETUP, WRITE} state_e;
  state_e state_q, state_d;
  logic [15:0] pc_q [DEPTH];
  logic [15:0] tgt_q [DEPTH];
  logic taken_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0] count_q;
  logic [1:0] cnt_q [N];
  logic [15-IDX_W:0] tag_q [N];
  logic [N-1:0] vld_q;
  logic [15:0] mis_q;
  logic push, commit, hit, taken, mis;
  logic [IDX_W-1:0] idx;
  logic [1:0] cur, cnt_d;
  logic [15:0] head_pc;
  always_comb begin
    head_pc = pc_q[rd_q];
    taken = taken_q[rd_q];
    idx = head_pc[IDX_W-1:0];
    cur = cnt_q[idx];
    hit = vld_q[idx] && tag_q[idx] == head_pc[15:IDX_W];
    cnt_d = !hit ? (taken ? 2'b10 : 2'b01)
          : taken ? (cur == 2'b11 ? cur : cur + 2'd1)
          : (cur == 2'b00 ? cur : cur - 2'd1);
    mis = hit ? cur[1] != taken : taken;
    push = bus.res_valid && bus.res_ready;
    commit = state_q == WRITE && bus.btb_write_ok;
    state_d = state_q == IDLE ? (count_q != '0 ? SETUP : IDLE)
            : state_q == SETUP ? WRITE
            : commit ? IDLE : WRITE;
  end
  assign bus.res_ready = count_q != (PW+1)'(DEPTH);
  assign bus.loaded_pc = (state_q != IDLE || count_q != '0) ? head_pc : '0;
  assign bus.loaded_predict_pc = state_q == WRITE ? tgt_q[rd_q] : '0;
  assign bus.new_predict_val = state_q == WRITE && cnt_d[1];
  assign bus.load_line = commit;
  assign bus.mispredict_cnt = mis_q;
  // Payload storage and tags need no reset: valid bits and count gate every use
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_q] <= bus.res_pc;
      tgt_q[wr_q] <= bus.res_target;
      taken_q[wr_q] <= bus.res_taken;
    end
    if (commit) tag_q[idx] <= head_pc[15:IDX_W];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      vld_q <= '0;
      mis_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= 2'b01;
    end else begin
      state_q <= state_d;
      count_q <= count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, commit};
      if (push) wr_q <= wr_q + 1'b1;
      if (commit) begin
        rd_q <= rd_q + 1'b1;
        cnt_q[idx] <= cnt_d;
        vld_q[idx] <= 1'b1;
        if (mis && mis_q != '1) mis_q <= mis_q + 16'd1;
      end
    end
  end
endmodule
